// File: rtl/wims_ttl_pkg.sv
// Shared constants and types for the WIMS discrete-TTL models.
// Holds the 74163 slice width and the nibble type.
package wims_ttl_pkg;

    localparam int SLICE_W = 4;

    typedef logic [SLICE_W-1:0] nibble_t;

    localparam nibble_t NIBBLE_MAX = 4'hF;

endpackage

// File: rtl/ls74163_pc_slice.sv
// One 74163-style 4-bit synchronous counter slice.
// Sync reset > load > count (enp & ent) > hold; rco = ent & (q == F).
module ls74163
    import wims_ttl_pkg::*;
#(
    parameter nibble_t RESET_VALUE = 4'h0
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    enp,
    input  logic    ent,
    input  nibble_t d,
    output nibble_t q,
    output logic    rco
);

    // Counter register with the 74163 priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end else if (enp && ent) begin
            q <= q + nibble_t'(1);
        end
    end

    // Carry to the next slice is combinational and ignores enp.
    always_comb begin
        rco = ent && (q == NIBBLE_MAX);
    end

endmodule

// File: rtl/ls74163_pc.sv
// Program counter built from cascaded ls74163 slices.
// Define LS74163_PC_OVF_EN to add the sticky wrap flag output ovf.
module ls74163_pc
    import wims_ttl_pkg::*;
#(
    parameter int                           NIBBLES     = 2,
    parameter logic [SLICE_W*NIBBLES-1:0]   RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       enp,
    input  logic                       ent,
    input  logic [SLICE_W*NIBBLES-1:0] d,
    output logic [SLICE_W*NIBBLES-1:0] q,
    output logic                       rco
`ifdef LS74163_PC_OVF_EN
    ,
    output logic                       ovf
`endif
);

    // carry[i] is ent for slice i; carry[NIBBLES] is the top rco.
    logic [NIBBLES:0] carry;

    assign carry[0] = ent;
    assign rco      = carry[NIBBLES];

    for (genvar i = 0; i < NIBBLES; i++) begin : g_slice
        ls74163 #(
            .RESET_VALUE (RESET_VALUE[SLICE_W*i +: SLICE_W])
        ) u_slice (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .enp  (enp),
            .ent  (carry[i]),
            .d    (d[SLICE_W*i +: SLICE_W]),
            .q    (q[SLICE_W*i +: SLICE_W]),
            .rco  (carry[i+1])
        );
    end

`ifdef LS74163_PC_OVF_EN
    // Sticky flag: set when an enabled count leaves all-ones.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            ovf <= 1'b0;
        end else if (enp && carry[NIBBLES]) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/ls74163_pc.md
# ls74163_pc

Synchronous binary program counter built from cascaded 74163-style 4-bit counter slices, modelling the discrete-TTL PC of the WIMS CPU. It produces the instruction address that the downstream ls7408 gating stage ANDs with bus-enable masks. The counter supports parallel load (jumps), count enables and ripple-carry output, and cascades cleanly to wider address buses.

## Interface
Parameters:
- NIBBLES, 2, number of 4-bit slices; counter width W = 4*NIBBLES. Legal range is 1..8.
- RESET_VALUE, 0, W-bit value loaded on reset.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  synchronous parallel load of d; active-high.
- enp  input  1  count enable P, shared by all slices.
- ent  input  1  count enable T, fed to slice 0 only; it also qualifies rco.
- d  input  W  parallel load value (jump target).
- q  output  W  current count; the address fed downstream.
- rco  output  1  ripple carry out: ent AND (q == all ones). Combinational.

## Operation
- Priority on each rising edge: rst > load > count > hold.
- rst=1: q <= RESET_VALUE. The ovf flag is cleared, if built.
- load=1 (rst=0): q <= d, regardless of enp and ent.
- Count condition is enp & ent & !load & !rst. When it holds, q <= q + 1 modulo 2^W.
- Otherwise q holds its value.
- Slice i (i>0) receives ent_i = rco_{i-1}. Slice 0 receives ent_0 = ent.
- Slice i rco_i = ent_i & (q_i == 4'hF).
- Top-level rco = rco_{NIBBLES-1}.
- A slice increments only when enp & ent_i is true. This makes the cascade equivalent to a single W-bit incrementer.
- Wrap-around: when q = all ones, ent=1 and enp=1, the next q is 0.
- enp=0 with ent=1: q holds, but rco still reflects all-ones. rco is not gated by enp.
- load and rco: rco follows q combinationally. After a load of all ones with ent=1, rco rises in the same cycle that q updates.
- rst during load or count: rst wins, and the load data is discarded.
- No X propagation is allowed. Every output is defined from the first edge with rst=1.

## Timing
- Reset values: q = RESET_VALUE and ovf = 0. rco is 0 if RESET_VALUE is not all ones, otherwise rco = ent.
- Load latency: 1 cycle. d is sampled at edge k and appears on q after edge k.
- Increment latency: 1 cycle per enabled edge.
- rco has a combinational path from ent and q. Its delay grows with NIBBLES because the slices ripple; there is no added register stage.
- There is no handshake. Enables are level-sampled at each rising edge.

## Configuration
- LS74163_PC_OVF_EN defined:
  - adds the output port ovf (1 bit). ovf is a sticky flag.
  - ovf sets on the edge where q wraps from all ones to 0 through counting.
  - ovf clears on rst or load; if load and wrap occur on the same edge, load wins and ovf = 0.
- Undefined: the ovf port and its register are absent. All other behaviour is identical.

## Structure
- Shared package wims_ttl_pkg holds:
  - the constant SLICE_W = 4;
  - the nibble typedef, logic [3:0].
- Sub-module ls74163 implements one 4-bit slice:
  - ports: clk, rst, load, enp, ent, d[3:0], q[3:0], rco;
  - its reset value comes from a 4-bit parameter.
- The top-level instantiates NIBBLES slices in a generate loop. It chains rco to ent, and slices d and RESET_VALUE per nibble.

## Test plan
- Reset: NIBBLES=2, RESET_VALUE=8'h00, rst=1 for 1 edge -> q=8'h00, rco=0, ovf=0. Repeat with RESET_VALUE=8'h3C -> q=8'h3C.
- Count with cascade carry: load 8'h0E, then enp=ent=1 for 3 edges -> q = 8'h0F, 8'h10, 8'h11. Slice-1 rco stays 0 throughout.
- Wrap: load 8'hFE, enp=ent=1 -> q=8'hFF with rco=1, then q=8'h00 with rco=0. ovf=1 after the wrap and stays 1 for 3 further counts.
- Enable gating:
  - q=8'hFF, enp=0, ent=1 for 2 edges -> q holds 8'hFF and rco=1.
  - Then ent=0 -> rco=0 and q holds.
- Priority:
  - rst=1, load=1, d=8'hA5 -> q=RESET_VALUE.
  - Next edge load=1, enp=ent=1, d=8'hA5 -> q=8'hA5 with no increment, and ovf cleared.
- Width sweep: NIBBLES=1 and NIBBLES=4, counting from all-ones minus 2 for 4 edges -> q = max-1, max, 0, 1. rco is high only when q is at max.
